// File: rtl/ser2par_pkg.sv
// ser2par_pkg -- shared constants for the serial-to-parallel converter.
//
// Holds the default beat width, the default number of beats per word and the
// derived parallel word width. The parallel-to-serial converter on the other
// end of the link imports the same word width so both sides always agree.
// A helper sizes the beat counter.
package ser2par_pkg;

    localparam int SER2PAR_DWB   = 8 * 32;
    localparam int SER2PAR_NBEAT = 7;
    localparam int SER2PAR_DWO   = SER2PAR_NBEAT * SER2PAR_DWB;

    // Beat counter width. A single-beat word still needs one counter bit so
    // that the port and register declarations stay legal.
    function automatic int cnt_width(input int nbeat);
        return (nbeat > 1) ? $clog2(nbeat) : 1;
    endfunction

endpackage

// File: rtl/ser2par_if.sv
// ser2par_if -- serial input stream plus parallel output stream.
//
// Signals:
//   din      [DWB]  serial beat data            (source -> converter)
//   din_vld         beat valid                  (source -> converter)
//   din_rdy         converter can take a beat   (converter -> source)
//   dout     [DWO]  assembled parallel word     (converter -> sink)
//   dout_vld        dout holds a complete word  (converter -> sink)
//   dout_rdy        sink takes dout this cycle  (sink -> converter)
//
// Handshake: a transfer happens on a rising clk edge where vld && rdy are
// both high. The converter keeps dout/dout_vld stable while dout_vld is high
// and dout_rdy is low. din_rdy is a registered signal with no combinational
// path from din_vld or dout_rdy.
//
// Modports: slave = the converter, master = the bench / surrounding logic.
interface ser2par_if import ser2par_pkg::*; #(
    parameter int DWB = SER2PAR_DWB,
    parameter int DWO = SER2PAR_DWO
) ();

    logic [DWB-1:0] din;
    logic           din_vld;
    logic           din_rdy;
    logic [DWO-1:0] dout;
    logic           dout_vld;
    logic           dout_rdy;

    modport slave (
        input  din, din_vld, dout_rdy,
        output din_rdy, dout, dout_vld
    );

    modport master (
        output din, din_vld, dout_rdy,
        input  din_rdy, dout, dout_vld
    );

endinterface

// File: rtl/ser2par.sv
// ser2par -- collects NBEAT serial beats of DWB bits into one DWO-bit word.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   clr           synchronous clear, drops partial and held words
//   bus           ser2par_if.slave (din/din_vld/din_rdy, dout/dout_vld/dout_rdy)
//   dbg_cnt       current beat counter (next beat slot)
//   dbg_acc_full  accumulator holds a complete word waiting for the output
//
// Beat k of a word lands in bits [k*DWB +: DWB], so beat 0 is in the LSBs.
// Storage is double-buffered: an accumulator plus an output register. When
// the output register is busy and not being drained, a finished word parks in
// the accumulator and din_rdy drops until the output handshake moves it on.
module ser2par import ser2par_pkg::*; #(
    parameter int  DWB   = SER2PAR_DWB,
    parameter int  NBEAT = SER2PAR_NBEAT,
    parameter int  DWO   = NBEAT * DWB,
    localparam int CW    = cnt_width(NBEAT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    ser2par_if.slave      bus,
    output logic [CW-1:0] dbg_cnt,
    output logic          dbg_acc_full
);

    localparam logic [CW-1:0] LAST_BEAT = CW'(NBEAT - 1);

    logic [CW-1:0]  cnt_q, cnt_d;
    logic           acc_full_q, acc_full_d;
    logic           out_full_q, out_full_d;
    logic [DWO-1:0] acc_q, acc_d;
    logic [DWO-1:0] out_q, out_d;

    logic [DWO-1:0] acc_word;   // accumulator with this cycle's beat merged in
    logic           in_hs;
    logic           out_hs;
    logic           last_beat;

    assign bus.din_rdy  = !acc_full_q;
    assign bus.dout     = out_q;
    assign bus.dout_vld = out_full_q;

    assign dbg_cnt      = cnt_q;
    assign dbg_acc_full = acc_full_q;

    always_comb begin
        in_hs     = bus.din_vld && !acc_full_q;
        out_hs    = out_full_q && bus.dout_rdy;
        last_beat = in_hs && (cnt_q == LAST_BEAT);

        acc_word = acc_q;
        for (int k = 0; k < NBEAT; k++) begin
            if (in_hs && (cnt_q == CW'(k))) begin
                acc_word[k*DWB +: DWB] = bus.din;
            end
        end

        cnt_d      = cnt_q;
        acc_full_d = acc_full_q;
        out_full_d = out_full_q;
        acc_d      = acc_q;
        out_d      = out_q;

        if (clr) begin
            cnt_d      = '0;
            acc_full_d = 1'b0;
            out_full_d = 1'b0;
            acc_d      = '0;
            out_d      = '0;
        end else begin
            if (in_hs) begin
                cnt_d = last_beat ? '0 : cnt_q + 1'b1;
                acc_d = acc_word;
            end

            if (acc_full_q) begin
                // No beat can be taken here (din_rdy is low); only a drain
                // of the output register lets the parked word move on.
                if (out_hs) begin
                    out_d      = acc_q;
                    acc_d      = '0;
                    acc_full_d = 1'b0;
                end
            end else if (last_beat) begin
                if (!out_full_q || bus.dout_rdy) begin
                    // Output is free or being drained on this same edge.
                    out_d      = acc_word;
                    out_full_d = 1'b1;
                    acc_d      = '0;
                end else begin
                    acc_full_d = 1'b1;
                end
            end else if (out_hs) begin
                // Nothing to replace the drained word: dout returns to zero.
                out_full_d = 1'b0;
                out_d      = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            acc_full_q <= 1'b0;
            out_full_q <= 1'b0;
            acc_q      <= '0;
            out_q      <= '0;
        end else begin
            cnt_q      <= cnt_d;
            acc_full_q <= acc_full_d;
            out_full_q <= out_full_d;
            acc_q      <= acc_d;
            out_q      <= out_d;
        end
    end

endmodule

// File: doc/ser2par.md
SER2PAR -- requirements
Module: ser2par

Interface
REQ-001 Parameter DWB, default 8*32: width of one serial beat.
REQ-002 Parameter NBEAT, default 7: beats per parallel word.
REQ-003 Parameter DWO, default NBEAT*DWB: parallel output width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 clr  input  1  synchronous clear; drops partial and held words.
REQ-007 din  input  DWB  serial beat data.
REQ-008 din_vld  input  1  beat valid.
REQ-009 din_rdy  output  1  block can accept a beat this cycle.
REQ-010 dout  output  DWO  assembled parallel word.
REQ-011 dout_vld  output  1  dout holds a complete word.
REQ-012 dout_rdy  input  1  downstream accepts dout this cycle.

Function
REQ-013 A beat SHALL be accepted only on a cycle where din_vld && din_rdy.
REQ-014 The k-th accepted beat of a word, k = 0..NBEAT-1, SHALL land in accumulator slice [k*DWB +: DWB], so beat 0 is in the LSBs.
REQ-015 The beat counter SHALL advance on each accepted beat and wrap from NBEAT-1 to 0.
REQ-016 Storage SHALL be double-buffered: one accumulator plus one output register.
  - State: acc_full flag, out_full flag (= dout_vld).
REQ-017 On acceptance of beat NBEAT-1, handling depends on the output register:
  - If out_full is 0, or out_full is 1 with dout_rdy high that cycle: the complete word SHALL load into the output register on the same edge, with dout_vld high the next cycle (latency 1 cycle from the last beat).
  - Otherwise acc_full SHALL be set.
REQ-018 When acc_full = 1 and the output handshake (dout_vld && dout_rdy) occurs, the accumulator SHALL move to the output register on that edge, keep dout_vld = 1, and clear acc_full.
REQ-019 din_rdy SHALL equal !acc_full, a registered state only, with no combinational path from dout_rdy or din_vld.
REQ-020 A handshake with no pending word SHALL clear dout_vld on that edge.
REQ-021 Output stability while dout_vld && !dout_rdy: dout and dout_vld SHALL remain stable.
REQ-022 After the accumulator transfers to the output register, its contents SHALL be zeroed.
REQ-023 The output register SHALL be zeroed when dout_vld falls, so dout = 0 whenever dout_vld = 0.
REQ-024 Simultaneous events in one cycle SHALL all take effect: last-beat acceptance, output handshake, and transfer.
  - Sustained throughput SHALL be one beat per cycle, with no bubble between words while dout_rdy stays high.
REQ-025 clr SHALL have priority over all other events.
  - Next cycle: counter = 0, acc_full = 0, dout_vld = 0, dout = 0, accumulator = 0.
  - A beat presented in the clr cycle SHALL be discarded.
REQ-026 Out-of-range counter values SHALL NOT be reachable; the counter width SHALL be $clog2(NBEAT).

Reset
REQ-027 While rst = 1: din_rdy = 1, dout_vld = 0, dout = 0, counter = 0, acc_full = 0, accumulator = 0.
REQ-028 Reset asserted mid-word SHALL discard the partial word; no word SHALL emerge after rst releases until NBEAT new beats are accepted.
REQ-029 Reset release SHALL be synchronised by the system; the block SHALL require no extra cycles after release.

Structure
REQ-030 The shared package SHALL hold:
  - default beat width 8*32;
  - default NBEAT 7;
  - the derived word width, shared with the existing parallel-to-serial converter so both ends agree.
REQ-031 The block SHALL be one module with no sub-modules; the accumulator and output register SHALL be plain registers.

Verification
REQ-032 Reset values: assert rst mid-stream after 3 beats -> during reset din_rdy = 1, dout_vld = 0, dout = 0; then 7 fresh beats 0x11..0x77 produce exactly one word.
REQ-033 Single word: beats 1..7 on consecutive cycles with dout_rdy = 1 -> dout_vld high exactly 1 cycle after beat 7, with dout slice k = k+1.
REQ-034 Back-to-back: 21 beats continuous with dout_rdy = 1 -> 3 words, dout_vld pulses 7 cycles apart, din_rdy never low.
REQ-035 Backpressure: dout_rdy = 0, send 14 beats -> word A held stable, acc_full set, din_rdy = 0, beat 15 not accepted.
  - Raise dout_rdy one cycle -> word B appears the next cycle and din_rdy returns to 1.
REQ-036 Clear: after 4 beats plus one held word, pulse clr with din_vld = 1 -> next cycle dout_vld = 0, dout = 0; the next word is built from 7 new beats only.
REQ-037 Random din_vld/dout_rdy, 1000 words: scoreboard matches beat order and data; no loss, duplication or reordering.
